stu_lane_result_buffer: RTL and testbench

//  Stack-bus upstream lane receiver: consumes one PE result lane (pe__stu__lane_result_*), checks packet framing,

---
 rtl/stu_lane_result_buffer.sv | 187 ++++++++++++++++++
 tb/tb_stu_lane_result_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stu_lane_result_buffer.sv
// Stack-bus upstream lane receiver: framing check plus a DEPTH-entry beat FIFO toward the bus arbiter.
// Optional build macro STU_LANE_MASK_APPLY_EN: data is ANDed with mask on entry, mask forwarded all-ones.
module stu_lane_result_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNTL_W = 2,
  parameter int unsigned TYPE_W = 2,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic [TYPE_W-1:0] pe__stu__lane_type,
  input  logic              pe__stu__lane_result_data_valid,
  input  logic [CNTL_W-1:0] pe__stu__lane_result_cntl,
  input  logic [DATA_W-1:0] pe__stu__lane_result_data,
  input  logic [DATA_W-1:0] pe__stu__lane_result_data_mask,
  output logic              stu__pe__lane_result_ready,
  output logic              stu__bus__valid,
  output logic [TYPE_W-1:0] stu__bus__type,
  output logic [CNTL_W-1:0] stu__bus__cntl,
  output logic [DATA_W-1:0] stu__bus__data,
  output logic [DATA_W-1:0] stu__bus__mask,
  input  logic              bus__stu__ready,
  output logic [15:0]       stu__sys__pkt_count,
  output logic              stu__sys__framing_err,
  output logic              stu__sys__overflow_err,
  output logic              stu__sys__idle
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = CNTL_W'(0);
  localparam logic [CNTL_W-1:0] CNTL_SOM     = CNTL_W'(1);
  localparam logic [CNTL_W-1:0] CNTL_MOM     = CNTL_W'(2);
  localparam logic [CNTL_W-1:0] CNTL_EOM     = CNTL_W'(3);

  typedef enum logic [0:0] {StIdle, StInPkt} frame_state_e;

  frame_state_e state_q, state_d;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, idle_q;
  logic [15:0]       pkt_count_q;
  logic              framing_err_q, overflow_err_q;
  logic              frame_err_set;

  logic [TYPE_W-1:0] typ_mem  [DEPTH];
  logic [CNTL_W-1:0] cntl_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DATA_W-1:0] wdata;

  logic full, pop, push_req, push, overflow_set, head_is_eom;

  assign full = (count_q == FULL_CNT);
  assign pop  = stu__bus__valid & bus__stu__ready;

  // A full FIFO still takes a beat when the same edge pops; otherwise a full push is an overflow.
  assign push_req     = pe__stu__lane_result_data_valid & (ready_q | full);
  assign push         = push_req & (~full | pop);
  assign overflow_set = push_req & full & ~pop;

`ifdef STU_LANE_MASK_APPLY_EN
  assign wdata = pe__stu__lane_result_data & pe__stu__lane_result_data_mask;
`else
  assign wdata = pe__stu__lane_result_data;
`endif

  // Beat storage
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        typ_mem[i]  <= '0;
        cntl_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      typ_mem[wr_ptr_q]  <= pe__stu__lane_type;
      cntl_mem[wr_ptr_q] <= pe__stu__lane_result_cntl;
      data_mem[wr_ptr_q] <= wdata;
    end
  end

`ifndef STU_LANE_MASK_APPLY_EN
  logic [DATA_W-1:0] mask_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mask_mem[i] <= '0;
      end
    end else if (push) begin
      mask_mem[wr_ptr_q] <= pe__stu__lane_result_data_mask;
    end
  end

  assign stu__bus__mask = mask_mem[rd_ptr_q];
`else
  assign stu__bus__mask = '1;
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d < FULL_CNT);
      idle_q  <= (count_d == '0) && (state_d == StIdle);
    end
  end

  // Framing FSM: state register
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing FSM: next state; a stray SOM inside a packet restarts it, staying in StInPkt
  always_comb begin
    state_d = state_q;
    if (push) begin
      unique case (state_q)
        StIdle:  if (pe__stu__lane_result_cntl == CNTL_SOM) state_d = StInPkt;
        StInPkt: if (pe__stu__lane_result_cntl == CNTL_EOM) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Framing FSM: violation detect
  always_comb begin
    frame_err_set = 1'b0;
    if (push) begin
      unique case (state_q)
        StIdle:  frame_err_set = (pe__stu__lane_result_cntl == CNTL_MOM) ||
                                 (pe__stu__lane_result_cntl == CNTL_EOM);
        StInPkt: frame_err_set = (pe__stu__lane_result_cntl == CNTL_SOM) ||
                                 (pe__stu__lane_result_cntl == CNTL_SOM_EOM);
        default: frame_err_set = 1'b0;
      endcase
    end
  end

  assign head_is_eom = (cntl_mem[rd_ptr_q] == CNTL_EOM) || (cntl_mem[rd_ptr_q] == CNTL_SOM_EOM);

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      pkt_count_q    <= '0;
      framing_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      if (pop && head_is_eom) pkt_count_q <= pkt_count_q + 16'd1;
      if (frame_err_set)      framing_err_q  <= 1'b1;
      if (overflow_set)       overflow_err_q <= 1'b1;
    end
  end

  assign stu__pe__lane_result_ready = ready_q;
  assign stu__bus__valid            = (count_q != '0);
  assign stu__bus__type             = typ_mem[rd_ptr_q];
  assign stu__bus__cntl             = cntl_mem[rd_ptr_q];
  assign stu__bus__data             = data_mem[rd_ptr_q];
  assign stu__sys__pkt_count        = pkt_count_q;
  assign stu__sys__framing_err      = framing_err_q;
  assign stu__sys__overflow_err     = overflow_err_q;
  assign stu__sys__idle             = idle_q;

endmodule

// File: tb/tb_stu_lane_result_buffer.sv
// Directed self-checking bench for stu_lane_result_buffer (default DEPTH=8, DATA_W=32).
module tb_stu_lane_result_buffer;

  localparam logic [1:0] SOM_EOM = 2'b00;
  localparam logic [1:0] SOM     = 2'b01;
  localparam logic [1:0] MOM     = 2'b10;
  localparam logic [1:0] EOM     = 2'b11;

  logic        clk;
  logic        reset_poweron;
  logic [1:0]  pe__stu__lane_type;
  logic        pe__stu__lane_result_data_valid;
  logic [1:0]  pe__stu__lane_result_cntl;
  logic [31:0] pe__stu__lane_result_data;
  logic [31:0] pe__stu__lane_result_data_mask;
  logic        stu__pe__lane_result_ready;
  logic        stu__bus__valid;
  logic [1:0]  stu__bus__type;
  logic [1:0]  stu__bus__cntl;
  logic [31:0] stu__bus__data;
  logic [31:0] stu__bus__mask;
  logic        bus__stu__ready;
  logic [15:0] stu__sys__pkt_count;
  logic        stu__sys__framing_err;
  logic        stu__sys__overflow_err;
  logic        stu__sys__idle;

  int total;
  int bad;

  stu_lane_result_buffer dut (
    .clk                             (clk),
    .reset_poweron                   (reset_poweron),
    .pe__stu__lane_type              (pe__stu__lane_type),
    .pe__stu__lane_result_data_valid (pe__stu__lane_result_data_valid),
    .pe__stu__lane_result_cntl       (pe__stu__lane_result_cntl),
    .pe__stu__lane_result_data       (pe__stu__lane_result_data),
    .pe__stu__lane_result_data_mask  (pe__stu__lane_result_data_mask),
    .stu__pe__lane_result_ready      (stu__pe__lane_result_ready),
    .stu__bus__valid                 (stu__bus__valid),
    .stu__bus__type                  (stu__bus__type),
    .stu__bus__cntl                  (stu__bus__cntl),
    .stu__bus__data                  (stu__bus__data),
    .stu__bus__mask                  (stu__bus__mask),
    .bus__stu__ready                 (bus__stu__ready),
    .stu__sys__pkt_count             (stu__sys__pkt_count),
    .stu__sys__framing_err           (stu__sys__framing_err),
    .stu__sys__overflow_err          (stu__sys__overflow_err),
    .stu__sys__idle                  (stu__sys__idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat presented for exactly one edge
  task automatic send(input logic [1:0] c, input logic [31:0] d, input logic [31:0] m);
    pe__stu__lane_result_data_valid = 1'b1;
    pe__stu__lane_result_cntl       = c;
    pe__stu__lane_type              = d[1:0];
    pe__stu__lane_result_data       = d;
    pe__stu__lane_result_data_mask  = m;
    tick();
    pe__stu__lane_result_data_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(stu__pe__lane_result_ready), 32'd0);
    chk({tag, "_valid"}, 32'(stu__bus__valid), 32'd0);
    chk({tag, "_pkt"},   32'(stu__sys__pkt_count), 32'd0);
    chk({tag, "_ferr"},  32'(stu__sys__framing_err), 32'd0);
    chk({tag, "_oerr"},  32'(stu__sys__overflow_err), 32'd0);
    chk({tag, "_idle"},  32'(stu__sys__idle), 32'd0);
    chk({tag, "_data"},  stu__bus__data, 32'd0);
  endtask

  logic [31:0] exp_q[$];
  logic [1:0]  c;

  initial begin
    total = 0;
    bad   = 0;
    reset_poweron                   = 1'b0;
    pe__stu__lane_type              = '0;
    pe__stu__lane_result_data_valid = 1'b0;
    pe__stu__lane_result_cntl       = '0;
    pe__stu__lane_result_data       = '0;
    pe__stu__lane_result_data_mask  = '0;
    bus__stu__ready                 = 1'b0;

    #3;
    chk_all_zero("por");
    tick();
    reset_poweron = 1'b1;
    tick();
    chk("por_rel_ready", 32'(stu__pe__lane_result_ready), 32'd1);
    chk("por_rel_idle",  32'(stu__sys__idle), 32'd1);

    // 1: reset mid-packet with 3 beats buffered
    send(SOM, 32'h0000_0011, 32'hFFFF_FFFF);
    send(MOM, 32'h0000_0012, 32'hFFFF_FFFF);
    send(MOM, 32'h0000_0013, 32'hFFFF_FFFF);
    chk("t1_valid", 32'(stu__bus__valid), 32'd1);
    chk("t1_head",  stu__bus__data, 32'h0000_0011);
    #2;
    reset_poweron = 1'b0;
    #1;
    chk_all_zero("t1_rst");
    #1;
    reset_poweron = 1'b1;
    tick();
    chk("t1_rel_ready", 32'(stu__pe__lane_result_ready), 32'd1);
    chk("t1_rel_idle",  32'(stu__sys__idle), 32'd1);
    chk("t1_rel_valid", 32'(stu__bus__valid), 32'd0);

    // 2: single SOM_EOM beat
    bus__stu__ready = 1'b1;
    send(SOM_EOM, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    chk("t2_valid", 32'(stu__bus__valid), 32'd1);
    chk("t2_data",  stu__bus__data, 32'hDEAD_BEEF);
    chk("t2_type",  32'(stu__bus__type), 32'd3);
    chk("t2_cntl",  32'(stu__bus__cntl), 32'(SOM_EOM));
    tick();
    chk("t2_pkt",   32'(stu__sys__pkt_count), 32'd1);
    chk("t2_drain", 32'(stu__bus__valid), 32'd0);
    chk("t2_idle",  32'(stu__sys__idle), 32'd1);

    // 3: 8-beat packet into a stalled bus
    bus__stu__ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = (i == 0) ? SOM : ((i == 7) ? EOM : MOM);
      send(c, 32'h100 + 32'(i), 32'hFFFF_FFFF);
      if (i == 6) chk("t3_ready7", 32'(stu__pe__lane_result_ready), 32'd1);
    end
    chk("t3_ready_full", 32'(stu__pe__lane_result_ready), 32'd0);
    chk("t3_oerr",       32'(stu__sys__overflow_err), 32'd0);
    chk("t3_ferr",       32'(stu__sys__framing_err), 32'd0);
    bus__stu__ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_valid", 32'(stu__bus__valid), 32'd1);
      chk("t3_data",  stu__bus__data, 32'h100 + 32'(k));
      tick();
      if (k == 0) chk("t3_ready_back", 32'(stu__pe__lane_result_ready), 32'd1);
    end
    chk("t3_empty", 32'(stu__bus__valid), 32'd0);
    chk("t3_pkt",   32'(stu__sys__pkt_count), 32'd2);

    // 4: push and pop on the same edge while full
    bus__stu__ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = (i == 0) ? SOM : ((i == 7) ? EOM : MOM);
      send(c, 32'h200 + 32'(i), 32'hFFFF_FFFF);
    end
    chk("t4_full_ready", 32'(stu__pe__lane_result_ready), 32'd0);
    bus__stu__ready = 1'b1;
    send(SOM_EOM, 32'h0000_02FF, 32'hFFFF_FFFF);
    chk("t4_ready", 32'(stu__pe__lane_result_ready), 32'd0);
    chk("t4_oerr",  32'(stu__sys__overflow_err), 32'd0);
    chk("t4_head",  stu__bus__data, 32'h0000_0201);
    exp_q = '{32'h201, 32'h202, 32'h203, 32'h204, 32'h205, 32'h206, 32'h207, 32'h2FF};
    foreach (exp_q[k]) begin
      chk("t4_valid", 32'(stu__bus__valid), 32'd1);
      chk("t4_data",  stu__bus__data, exp_q[k]);
      tick();
    end
    chk("t4_empty", 32'(stu__bus__valid), 32'd0);
    chk("t4_pkt",   32'(stu__sys__pkt_count), 32'd4);
    chk("t4_ferr",  32'(stu__sys__framing_err), 32'd0);

    // 5: framing violations still deliver beats
    send(MOM, 32'h0000_0301, 32'hFFFF_FFFF);
    chk("t5_ferr1", 32'(stu__sys__framing_err), 32'd1);
    chk("t5_d1",    stu__bus__data, 32'h0000_0301);
    send(SOM, 32'h0000_0302, 32'hFFFF_FFFF);
    chk("t5_d2",    stu__bus__data, 32'h0000_0302);
    send(SOM, 32'h0000_0303, 32'hFFFF_FFFF);
    chk("t5_d3",    stu__bus__data, 32'h0000_0303);
    chk("t5_ferr3", 32'(stu__sys__framing_err), 32'd1);
    tick();
    chk("t5_empty", 32'(stu__bus__valid), 32'd0);
    chk("t5_inpkt_idle", 32'(stu__sys__idle), 32'd0);
    chk("t5_pkt",   32'(stu__sys__pkt_count), 32'd4);
    send(EOM, 32'h0000_0304, 32'hFFFF_FFFF);
    chk("t5_d4",    stu__bus__data, 32'h0000_0304);
    tick();
    chk("t5_pkt2",  32'(stu__sys__pkt_count), 32'd5);
    chk("t5_idle",  32'(stu__sys__idle), 32'd1);

    // 6: mask handling
    bus__stu__ready = 1'b0;
    send(SOM_EOM, 32'h1234_5678, 32'h0000_FFFF);
`ifdef STU_LANE_MASK_APPLY_EN
    chk("t6_data", stu__bus__data, 32'h0000_5678);
    chk("t6_mask", stu__bus__mask, 32'hFFFF_FFFF);
`else
    chk("t6_data", stu__bus__data, 32'h1234_5678);
    chk("t6_mask", stu__bus__mask, 32'h0000_FFFF);
`endif
    bus__stu__ready = 1'b1;
    tick();
    chk("t6_pkt", 32'(stu__sys__pkt_count), 32'd6);

    // 7: push into a full FIFO with no pop is dropped and flagged
    bus__stu__ready = 1'b0;
    for (int i = 0; i < 8; i++) send(SOM_EOM, 32'h400 + 32'(i), 32'hFFFF_FFFF);
    chk("t7_oerr0", 32'(stu__sys__overflow_err), 32'd0);
    send(SOM_EOM, 32'h0000_04FF, 32'hFFFF_FFFF);
    chk("t7_oerr1", 32'(stu__sys__overflow_err), 32'd1);
    chk("t7_ready", 32'(stu__pe__lane_result_ready), 32'd0);
    bus__stu__ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t7_data", stu__bus__data, 32'h400 + 32'(k));
      tick();
    end
    chk("t7_empty", 32'(stu__bus__valid), 32'd0);
    chk("t7_pkt",   32'(stu__sys__pkt_count), 32'd14);
    chk("t7_ferr",  32'(stu__sys__framing_err), 32'd1);

    // Sticky errors clear only on reset
    reset_poweron = 1'b0;
    #1;
    chk("rst_ferr", 32'(stu__sys__framing_err), 32'd0);
    chk("rst_oerr", 32'(stu__sys__overflow_err), 32'd0);
    chk("rst_pkt",  32'(stu__sys__pkt_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
